// File: rtl/restoring_divider_pkg.sv
// Shared constants and state encoding for the restoring divider.
// Signed operation is enabled with RESTORING_DIVIDER_SIGNED_EN.
package restoring_divider_pkg;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Start/busy/done handshake and operand/result bundle of the divider.
// master drives requests, slave is the divider.
import restoring_divider_pkg::*;

interface restoring_divider_if #(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div0;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div0
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div0
    );
endinterface

// File: rtl/restoring_divider_div_sub_stage.sv
// Trial subtractor: WIDTH+1-bit difference, MSB is the borrow.
import restoring_divider_pkg::*;

module div_sub_stage #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    logic [WIDTH:0] trial;

    assign trial  = {1'b0, a} - {1'b0, b};
    assign diff   = trial[WIDTH-1:0];
    assign borrow = trial[WIDTH];
endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands.
import restoring_divider_pkg::*;

module restoring_divider #(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic                clk,
    input logic                rst,
    restoring_divider_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    div_state_t       state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q, r, dvs;
    logic [WIDTH-1:0] quo, rem;
    logic             dz;
    logic [WIDTH-1:0] r_sh, diff, q_nx, r_nx;
    logic             borrow;
    logic             accept;

    assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a      (r_sh),
        .b      (dvs),
        .diff   (diff),
        .borrow (borrow)
    );

    assign q_nx = {q[WIDTH-2:0], ~borrow};
    assign r_nx = borrow ? r_sh : diff;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                accept = bus.start;
                if (bus.start) state_n = RUN;
            end
            RUN: begin
                if (cnt == '0) state_n = DONE;
            end
            DONE: begin
                accept  = bus.start;
                state_n = bus.start ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
    logic sa, sb;

    assign sa = bus.dividend[WIDTH-1];
    assign sb = bus.divisor[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
                q   <= sa ? -bus.dividend : bus.dividend;
                dvs <= sb ? -bus.divisor : bus.divisor;
`else
                q   <= bus.dividend;
                dvs <= bus.divisor;
`endif
                r   <= '0;
                cnt <= CW'(WIDTH - 1);
                quo <= '0;
                rem <= '0;
                dz  <= 1'b0;
            end else if (state == RUN) begin
                q <= q_nx;
                r <= r_nx;
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    dz <= (dvs == '0);
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    // zero divisor must read back as -1, not a negated all-ones
                    quo <= (dvs == '0) ? '1 : (neg_q ? -q_nx : q_nx);
                    rem <= neg_r ? -r_nx : r_nx;
`else
                    quo <= q_nx;
                    rem <= r_nx;
`endif
                end
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
    assign bus.div0      = dz;
endmodule

// File: tb/tb_restoring_divider.sv
// Randomized self-checking bench for restoring_divider against an
// arithmetic reference model.
module tb_restoring_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(W)) bus ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        z = (b == '0);
`ifdef RESTORING_DIVIDER_SIGNED_EN
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end
`else
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Launches one operation from IDLE/DONE and waits for its done pulse.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      output logic [W-1:0] q, output logic [W-1:0] r,
                      output logic z, output int lat, output int nbusy);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        nbusy = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div0;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        int lat, nb;
        model(a, b, eq, er, ez);
        op(a, b, q, r, z, lat, nb);
        compared++;
        if (lat !== W + 1 || nb !== W) begin
            mismatched++;
            $display("FAIL %s timing: lat=%0d busy=%0d want lat=%0d busy=%0d",
                     name, lat, nb, W + 1, W);
        end
        compared++;
        if (q !== eq || r !== er || z !== ez) begin
            mismatched++;
            $display("FAIL %s %h/%h: got q=%h r=%h z=%b want q=%h r=%h z=%b",
                     name, a, b, q, r, z, eq, er, ez);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.busy, bus.done, bus.div0} !== 3'b000 ||
            bus.quotient !== '0 || bus.remainder !== '0) begin
            mismatched++;
            $display("FAIL reset: busy=%b done=%b div0=%b q=%h r=%h want all 0",
                     bus.busy, bus.done, bus.div0, bus.quotient, bus.remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        check_op("basic", 32'd100, 32'd7);
        @(negedge clk);
        compared++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 32'd14) begin
            mismatched++;
            $display("FAIL hold: done=%b busy=%b q=%h want 0 0 0000000e",
                     bus.done, bus.busy, bus.quotient);
        end
    endtask

    task automatic test_edges();
        check_op("max_by_1", 32'hFFFFFFFF, 32'd1);
        check_op("small_by_big", 32'd5, 32'd9);
        check_op("div0", 32'h5AF25A5E, 32'd0);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = W'($urandom_range(0, 15));
            if (i % 4 == 1) b = b >> $urandom_range(0, 31);
            check_op("random", a, b);
        end
    endtask

    task automatic test_busy_start();
        logic [W-1:0] eq, er;
        logic ez;
        int lat;
        model(32'd1000, 32'd33, eq, er, ez);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd33;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.dividend = 32'd77;
                bus.divisor = 32'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        compared++;
        if (lat !== W + 1 || bus.quotient !== eq || bus.remainder !== er) begin
            mismatched++;
            $display("FAIL busy_start: lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, bus.quotient, bus.remainder, W + 1, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r, eq, er;
        logic z, ez;
        int lat, nb;
        op(32'd500, 32'd6, q, r, z, lat, nb);
        // still in the done cycle: request the next operation now
        bus.start = 1'b1;
        bus.dividend = 32'hDEADBEEF;
        bus.divisor = 32'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        compared++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== '0) begin
            mismatched++;
            $display("FAIL b2b_accept: busy=%b done=%b q=%h want 1 0 0",
                     bus.busy, bus.done, bus.quotient);
        end
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        model(32'hDEADBEEF, 32'h1234, eq, er, ez);
        compared++;
        if (lat !== W + 1 || bus.quotient !== eq || bus.remainder !== er) begin
            mismatched++;
            $display("FAIL b2b_second: lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                     lat, bus.quotient, bus.remainder, W + 1, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 32'd123456;
        bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({bus.busy, bus.done, bus.div0} !== 3'b000 ||
            bus.quotient !== '0 || bus.remainder !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: busy=%b done=%b div0=%b q=%h r=%h want all 0",
                     bus.busy, bus.done, bus.div0, bus.quotient, bus.remainder);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            @(negedge clk);
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_abort: activity cycles=%0d want 0", seen);
        end
        check_op("after_reset", 32'd9, 32'd3);
    endtask

`ifdef RESTORING_DIVIDER_SIGNED_EN
    task automatic test_signed();
        check_op("neg7_by_2", -32'sd7, 32'd2);
        check_op("overflow", 32'h80000000, 32'hFFFFFFFF);
        check_op("neg_div0", 32'hFFFFFF00, 32'd0);
        check_op("neg_by_neg", -32'sd100, -32'sd7);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
`ifdef RESTORING_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
